// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: data word, RAM handshake state,
// coherence FSM state and the RAM request bundle.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [3:0] {
    IDLE,
    ARB,
    IFETCH,
    WB0,
    WB1,
    SNOOP,
    C2C0,
    C2C1,
    LD0,
    LD1,
    INV
  } ccstate_t;

  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;
  } ramreq_t;

endpackage

// File: rtl/cache_control_if.sv
// Cache/RAM <-> coherence controller bundle.
// cc: controller side; caches: icache/dcache + RAM side.
interface cache_control_if #(
  parameter int CPUS = 2
);
  import cpu_types_pkg::*;

  logic [CPUS-1:0] iREN, dREN, dWEN;
  logic [CPUS-1:0] ccwrite, cctrans;
  logic [CPUS-1:0] iwait, dwait;
  logic [CPUS-1:0] ccwait, ccinv;
  word_t iaddr  [CPUS];
  word_t daddr  [CPUS];
  word_t dstore [CPUS];
  word_t iload  [CPUS];
  word_t dload  [CPUS];
  word_t ccsnoopaddr [CPUS];
  word_t ramload, ramaddr, ramstore;
  ramstate_t ramstate;
  logic ramREN, ramWEN;

  modport cc (
    input  iREN, dREN, dWEN,
    input  iaddr, daddr, dstore,
    input  ccwrite, cctrans,
    input  ramload, ramstate,
    output iwait, dwait, iload, dload,
    output ccwait, ccinv, ccsnoopaddr,
    output ramaddr, ramstore,
    output ramREN, ramWEN
  );

  modport caches (
    output iREN, dREN, dWEN,
    output iaddr, daddr, dstore,
    output ccwrite, cctrans,
    output ramload, ramstate,
    input  iwait, dwait, iload, dload,
    input  ccwait, ccinv, ccsnoopaddr,
    input  ramaddr, ramstore,
    input  ramREN, ramWEN
  );

endinterface

// File: rtl/cc_rr_arbiter.sv
// Two-CPU priority/round-robin grant: writes, then
// coherence/data reads, then ifetch; ptr breaks ties.
module cc_rr_arbiter (
  input  logic       ptr,
  input  logic [1:0] wreq,
  input  logic [1:0] rreq,
  input  logic [1:0] ireq,
  output logic       gnt,
  output logic       any
);

  function automatic logic pick(
    input logic [1:0] req,
    input logic       p
  );
    return req[p] ? p : ~p;
  endfunction

  assign any = |{wreq, rreq, ireq};

  always_comb begin
    gnt = ptr;
    priority case (1'b1)
      |wreq:   gnt = pick(wreq, ptr);
      |rreq:   gnt = pick(rreq, ptr);
      |ireq:   gnt = pick(ireq, ptr);
      default: gnt = ptr;
    endcase
  end

endmodule

// File: rtl/memory_coherence_ctrl.sv
// MSI bus controller for two icache/dcache pairs and one RAM.
// Ports: CLK, RST (sync, active-high), ccif (cache_control_if.cc).
module memory_coherence_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input logic         CLK,
  input logic         RST,
  cache_control_if.cc ccif
);

  ccstate_t state, nstate;
  logic g, p, ptr, gnt, any;
  logic acc, done;
  logic [CPUS-1:0] rreq;
  ramreq_t ram;

  assign p    = ~g;
  assign acc  = (ccif.ramstate == ACCESS);
  assign rreq = ccif.cctrans | ccif.dREN;

  cc_rr_arbiter u_arb (
    .ptr  (ptr),
    .wreq (ccif.dWEN),
    .rreq (rreq),
    .ireq (ccif.iREN),
    .gnt  (gnt),
    .any  (any)
  );

  // A transaction is finished when a working state returns to IDLE;
  // ARB falling back to IDLE (request dropped) is not a completion.
  assign done = (nstate == IDLE) &&
                (state != IDLE) && (state != ARB);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      g     <= 1'b0;
      ptr   <= 1'b0;
    end else begin
      state <= nstate;
      if (state == ARB) g <= gnt;
      if (done) ptr <= ~g;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:
        if (any) nstate = ARB;
      ARB:
        if (ccif.dWEN[gnt])
          nstate = WB0;
        else if (ccif.cctrans[gnt] || ccif.dREN[gnt])
          nstate = SNOOP;
        else if (ccif.iREN[gnt])
          nstate = IFETCH;
        else
          nstate = IDLE;
      IFETCH: if (acc) nstate = IDLE;
      WB0:    if (acc) nstate = WB1;
      WB1:    if (acc) nstate = IDLE;
      SNOOP:
        // Peer in M supplies the block and writes it back.
        if (ccif.cctrans[p] && ccif.ccwrite[p])
          nstate = C2C0;
        else if (ccif.dREN[g])
          nstate = LD0;
        else
          nstate = INV;
      C2C0:   if (acc) nstate = C2C1;
      C2C1:   if (acc) nstate = IDLE;
      LD0:    if (acc) nstate = LD1;
      LD1:    if (acc) nstate = IDLE;
      INV:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    ccif.iwait       = '1;
    ccif.dwait       = '1;
    ccif.ccwait      = '0;
    ccif.ccinv       = '0;
    ccif.iload       = '{default: '0};
    ccif.dload       = '{default: '0};
    ccif.ccsnoopaddr = '{default: '0};
    ram              = '0;
    unique case (state)
      IFETCH: begin
        ram.ren          = 1'b1;
        ram.addr         = ccif.iaddr[g];
        ccif.iload[g]    = ccif.ramload;
        ccif.iwait[g]    = ~acc;
      end
      WB0, WB1: begin
        ram.wen          = 1'b1;
        ram.addr         = ccif.daddr[g];
        ram.store        = ccif.dstore[g];
        ccif.dwait[g]    = ~acc;
      end
      SNOOP: begin
        ccif.ccwait[p]      = 1'b1;
        ccif.ccsnoopaddr[p] = ccif.daddr[g];
        ccif.ccinv[p]       = ccif.ccwrite[g];
      end
      C2C0, C2C1: begin
        ccif.ccwait[p]   = 1'b1;
        ccif.dload[g]    = ccif.dstore[p];
        ram.wen          = 1'b1;
        ram.addr         = ccif.daddr[p];
        ram.store        = ccif.dstore[p];
        ccif.dwait[g]    = ~acc;
        ccif.dwait[p]    = ~acc;
      end
      LD0, LD1: begin
        ccif.ccwait[p]   = 1'b1;
        ram.ren          = 1'b1;
        ram.addr         = ccif.daddr[g];
        ccif.dload[g]    = ccif.ramload;
        ccif.dwait[g]    = ~acc;
      end
      INV: begin
        ccif.ccinv[p]    = 1'b1;
        ccif.dwait[g]    = 1'b0;
      end
      default: ;
    endcase
  end

  assign ccif.ramREN   = ram.ren;
  assign ccif.ramWEN   = ram.wen;
  assign ccif.ramaddr  = ram.addr;
  assign ccif.ramstore = ram.store;

endmodule

// File: tb/tb_memory_coherence_ctrl.sv
// Directed bench for memory_coherence_ctrl: ifetch, C2C,
// upgrade, back-to-back writebacks, error hold, mid-load reset.
module tb_memory_coherence_ctrl;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  cache_control_if #(.CPUS(2)) ccif ();

  memory_coherence_ctrl #(.CPUS(2)) dut (
    .CLK  (clk),
    .RST  (rst),
    .ccif (ccif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    ccif.iREN     = '0;
    ccif.dREN     = '0;
    ccif.dWEN     = '0;
    ccif.ccwrite  = '0;
    ccif.cctrans  = '0;
    ccif.ramstate = FREE;
    ccif.ramload  = '0;
  endtask

  task automatic test_reset();
    clear_reqs();
    ccif.iaddr  = '{default: '0};
    ccif.daddr  = '{default: '0};
    ccif.dstore = '{default: '0};
    rst = 1'b1;
    tick();
    tick();
    #2;
    n_chk++;
    if (ccif.iwait !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_iwait: got %b want 11", ccif.iwait);
    end
    n_chk++;
    if (ccif.dwait !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_dwait: got %b want 11", ccif.dwait);
    end
    n_chk++;
    if ({ccif.ccwait, ccif.ccinv} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_cc: got %b want 0000",
               {ccif.ccwait, ccif.ccinv});
    end
    n_chk++;
    if ({ccif.ramREN, ccif.ramWEN} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_ram: got %b want 00",
               {ccif.ramREN, ccif.ramWEN});
    end
    n_chk++;
    if (ccif.ramaddr !== 32'h0 || ccif.iload[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_data: got %h/%h want 0",
               ccif.ramaddr, ccif.iload[0]);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ifetch();
    ccif.iREN[0]  = 1'b1;
    ccif.iaddr[0] = 32'h40;
    tick();
    #2;
    n_chk++;
    if (ccif.ramREN !== 1'b0) begin
      n_fail++;
      $display("FAIL if_arb_ren: got %b want 0", ccif.ramREN);
    end
    tick();
    ccif.ramstate = BUSY;
    #2;
    n_chk++;
    if (ccif.ramREN !== 1'b1 || ccif.ramaddr !== 32'h40) begin
      n_fail++;
      $display("FAIL if_req: got ren=%b addr=%h want 1/40",
               ccif.ramREN, ccif.ramaddr);
    end
    n_chk++;
    if (ccif.iwait[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL if_busy1: got %b want 1", ccif.iwait[0]);
    end
    tick();
    #2;
    n_chk++;
    if (ccif.iwait[0] !== 1'b1 || ccif.ramREN !== 1'b1) begin
      n_fail++;
      $display("FAIL if_busy2: got iwait=%b ren=%b want 1/1",
               ccif.iwait[0], ccif.ramREN);
    end
    tick();
    ccif.ramstate = ACCESS;
    ccif.ramload  = 32'hDEAD;
    #2;
    n_chk++;
    if (ccif.iwait !== 2'b10 || ccif.iload[0] !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL if_access: got iwait=%b iload=%h want 10/dead",
               ccif.iwait, ccif.iload[0]);
    end
    tick();
    clear_reqs();
    #2;
    n_chk++;
    if (ccif.iwait !== 2'b11 || ccif.ramREN !== 1'b0) begin
      n_fail++;
      $display("FAIL if_done: got iwait=%b ren=%b want 11/0",
               ccif.iwait, ccif.ramREN);
    end
  endtask

  // Pointer is at CPU1 after the CPU0 ifetch.
  task automatic test_c2c();
    ccif.dREN[1]    = 1'b1;
    ccif.cctrans[1] = 1'b1;
    ccif.daddr[1]   = 32'h80;
    ccif.cctrans[0] = 1'b1;
    ccif.ccwrite[0] = 1'b1;
    ccif.daddr[0]   = 32'h80;
    ccif.dstore[0]  = 32'h1234;
    tick();
    tick();
    #2;
    n_chk++;
    if (ccif.ccwait !== 2'b01 ||
        ccif.ccsnoopaddr[0] !== 32'h80) begin
      n_fail++;
      $display("FAIL c2c_snoop: got ccwait=%b addr=%h want 01/80",
               ccif.ccwait, ccif.ccsnoopaddr[0]);
    end
    n_chk++;
    if (ccif.ccinv !== 2'b00) begin
      n_fail++;
      $display("FAIL c2c_snoop_inv: got %b want 00", ccif.ccinv);
    end
    tick();
    ccif.ramstate = ACCESS;
    #2;
    n_chk++;
    if (ccif.dload[1] !== 32'h1234 || ccif.ramWEN !== 1'b1 ||
        ccif.ramREN !== 1'b0) begin
      n_fail++;
      $display("FAIL c2c0_xfer: got dload=%h wen=%b ren=%b want 1234/1/0",
               ccif.dload[1], ccif.ramWEN, ccif.ramREN);
    end
    n_chk++;
    if (ccif.ramaddr !== 32'h80 || ccif.ramstore !== 32'h1234) begin
      n_fail++;
      $display("FAIL c2c0_ram: got %h/%h want 80/1234",
               ccif.ramaddr, ccif.ramstore);
    end
    n_chk++;
    if (ccif.dwait !== 2'b00 || ccif.ccwait !== 2'b01) begin
      n_fail++;
      $display("FAIL c2c0_wait: got dwait=%b ccwait=%b want 00/01",
               ccif.dwait, ccif.ccwait);
    end
    tick();
    ccif.daddr[0]  = 32'h84;
    ccif.daddr[1]  = 32'h84;
    ccif.dstore[0] = 32'h5678;
    #2;
    n_chk++;
    if (ccif.dload[1] !== 32'h5678 || ccif.ramaddr !== 32'h84 ||
        ccif.dwait !== 2'b00) begin
      n_fail++;
      $display("FAIL c2c1: got %h/%h/%b want 5678/84/00",
               ccif.dload[1], ccif.ramaddr, ccif.dwait);
    end
    tick();
    clear_reqs();
    #2;
    n_chk++;
    if (ccif.dwait !== 2'b11 || ccif.ccwait !== 2'b00 ||
        ccif.ramWEN !== 1'b0) begin
      n_fail++;
      $display("FAIL c2c_done: got %b/%b/%b want 11/00/0",
               ccif.dwait, ccif.ccwait, ccif.ramWEN);
    end
  endtask

  task automatic test_inv();
    ccif.cctrans[0] = 1'b1;
    ccif.ccwrite[0] = 1'b1;
    ccif.daddr[0]   = 32'h100;
    tick();
    tick();
    #2;
    n_chk++;
    if (ccif.ccwait !== 2'b10 || ccif.ccinv !== 2'b10 ||
        ccif.ccsnoopaddr[1] !== 32'h100) begin
      n_fail++;
      $display("FAIL inv_snoop: got %b/%b/%h want 10/10/100",
               ccif.ccwait, ccif.ccinv, ccif.ccsnoopaddr[1]);
    end
    n_chk++;
    if (ccif.dwait[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL inv_snoop_dwait: got %b want 1", ccif.dwait[0]);
    end
    tick();
    #2;
    n_chk++;
    if (ccif.ccinv !== 2'b10 || ccif.dwait !== 2'b10) begin
      n_fail++;
      $display("FAIL inv_cycle: got ccinv=%b dwait=%b want 10/10",
               ccif.ccinv, ccif.dwait);
    end
    n_chk++;
    if ({ccif.ramREN, ccif.ramWEN} !== 2'b00) begin
      n_fail++;
      $display("FAIL inv_ram: got %b want 00",
               {ccif.ramREN, ccif.ramWEN});
    end
    tick();
    clear_reqs();
    #2;
    n_chk++;
    if (ccif.ccinv !== 2'b00 || ccif.dwait !== 2'b11) begin
      n_fail++;
      $display("FAIL inv_done: got %b/%b want 00/11",
               ccif.ccinv, ccif.dwait);
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ccif.dWEN      = 2'b11;
    ccif.daddr[0]  = 32'h200;
    ccif.dstore[0] = 32'hA0;
    ccif.daddr[1]  = 32'h300;
    ccif.dstore[1] = 32'hB0;
    ccif.ramstate  = ACCESS;
    tick();
    tick();
    #2;
    n_chk++;
    if (ccif.ramWEN !== 1'b1 || ccif.ramaddr !== 32'h200 ||
        ccif.ramstore !== 32'hA0) begin
      n_fail++;
      $display("FAIL b2b_wb0_cpu0: got %b/%h/%h want 1/200/a0",
               ccif.ramWEN, ccif.ramaddr, ccif.ramstore);
    end
    n_chk++;
    if (ccif.dwait !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_wb0_dwait: got %b want 10", ccif.dwait);
    end
    tick();
    ccif.daddr[0]  = 32'h204;
    ccif.dstore[0] = 32'hA1;
    #2;
    n_chk++;
    if (ccif.ramaddr !== 32'h204 || ccif.ramstore !== 32'hA1 ||
        ccif.dwait !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_wb1_cpu0: got %h/%h/%b want 204/a1/10",
               ccif.ramaddr, ccif.ramstore, ccif.dwait);
    end
    tick();
    ccif.dWEN[0] = 1'b0;
    #2;
    n_chk++;
    if (ccif.ramWEN !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap_idle: got %b want 0", ccif.ramWEN);
    end
    tick();
    #2;
    n_chk++;
    if (ccif.ramWEN !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap_arb: got %b want 0", ccif.ramWEN);
    end
    tick();
    #2;
    n_chk++;
    if (ccif.ramaddr !== 32'h300 || ccif.ramstore !== 32'hB0 ||
        ccif.dwait !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_wb0_cpu1: got %h/%h/%b want 300/b0/01",
               ccif.ramaddr, ccif.ramstore, ccif.dwait);
    end
    tick();
    #2;
    n_chk++;
    if (ccif.ramWEN !== 1'b1 || ccif.dwait !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_wb1_cpu1: got %b/%b want 1/01",
               ccif.ramWEN, ccif.dwait);
    end
    tick();
    clear_reqs();
  endtask

  // Pointer is back at CPU0 after the CPU1 writeback.
  task automatic test_reset_mid_ld();
    ccif.dREN[0]    = 1'b1;
    ccif.cctrans[0] = 1'b1;
    ccif.daddr[0]   = 32'h400;
    ccif.ramstate   = BUSY;
    tick();
    tick();
    tick();
    ccif.ramstate = ERROR;
    ccif.ramload  = 32'hCAFE;
    #2;
    n_chk++;
    if (ccif.ramREN !== 1'b1 || ccif.ramaddr !== 32'h400 ||
        ccif.ccwait !== 2'b10 || ccif.dwait !== 2'b11) begin
      n_fail++;
      $display("FAIL ld0_req: got %b/%h/%b/%b want 1/400/10/11",
               ccif.ramREN, ccif.ramaddr, ccif.ccwait, ccif.dwait);
    end
    tick();
    #2;
    n_chk++;
    if (ccif.ramREN !== 1'b1 || ccif.dwait[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ld0_err_hold: got ren=%b dwait=%b want 1/1",
               ccif.ramREN, ccif.dwait[0]);
    end
    ccif.ramstate = ACCESS;
    #2;
    n_chk++;
    if (ccif.dwait[0] !== 1'b0 || ccif.dload[0] !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL ld0_access: got %b/%h want 0/cafe",
               ccif.dwait[0], ccif.dload[0]);
    end
    tick();
    ccif.daddr[0] = 32'h404;
    #2;
    n_chk++;
    if (ccif.ramREN !== 1'b1 || ccif.ramaddr !== 32'h404) begin
      n_fail++;
      $display("FAIL ld1_req: got %b/%h want 1/404",
               ccif.ramREN, ccif.ramaddr);
    end
    rst = 1'b1;
    tick();
    clear_reqs();
    rst = 1'b0;
    #2;
    n_chk++;
    if (ccif.ramREN !== 1'b0 || ccif.ramWEN !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_rst_ram: got %b/%b want 0/0",
               ccif.ramREN, ccif.ramWEN);
    end
    n_chk++;
    if (ccif.iwait !== 2'b11 || ccif.dwait !== 2'b11 ||
        ccif.ccwait !== 2'b00) begin
      n_fail++;
      $display("FAIL ld_rst_wait: got %b/%b/%b want 11/11/00",
               ccif.iwait, ccif.dwait, ccif.ccwait);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ifetch();
    test_c2c();
    test_inv();
    test_back_to_back();
    test_reset_mid_ld();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
